cache_ctrl_fifo2w: RTL and testbench
====================================

CACHE_CTRL_FIFO2W -- requirements
Module: cache_ctrl_fifo2w

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port: cpu_req  in  1  CPU access request, sampled in IDLE only.
REQ-004 SHALL have port: cpu_we  in  1  1 = write, 0 = read; latched with cpu_req.
REQ-005 SHALL have port: cpu_index  in  3  line index; latched with cpu_req.
REQ-006 SHALL have port: hit  in  1  tag-compare result for the latched index; valid in LOOKUP.
REQ-007 SHALL have port: hit_way  in  1  way that hit; valid in LOOKUP when hit=1.
REQ-008 SHALL have port: mem_ack  in  1  memory completion, one-cycle pulse.
REQ-009 SHALL have port: mem_req  out  1  memory request, level.
REQ-010 SHALL have port: mem_we  out  1  memory write qualifier, valid while mem_req=1.
REQ-011 SHALL have port: fill_en  out  1  one-cycle strobe: write refill line into cache.
REQ-012 SHALL have port: fill_way  out  1  victim way for fill.
REQ-013 SHALL have port: upd_en  out  1  one-cycle strobe: write-hit update of cached word.
REQ-014 SHALL have port: upd_way  out  1  way to update.
REQ-015 SHALL have port: line_index  out  3  latched index, drives cache arrays.
REQ-016 SHALL have port: cpu_ready  out  1  one-cycle completion pulse to CPU.
REQ-017 SHALL have port: state  out  3  current FSM state encoding, for debug.

Function
REQ-018 SHALL implement FSM states IDLE=0, LOOKUP=1, MEM_RD=2, FILL=3, MEM_WR=4, DONE=5.
REQ-019 SHALL, in IDLE with cpu_req=1, latch cpu_we and cpu_index and go to LOOKUP; cpu_req=0 stays IDLE.
REQ-020 SHALL ignore cpu_req in every state other than IDLE (no queuing).
REQ-021 SHALL, in LOOKUP on a read: hit=1 -> DONE; hit=0 -> MEM_RD.
REQ-022 SHALL, in LOOKUP on a write, go to MEM_WR (write-through, no write-allocate); on hit=1 it SHALL also assert upd_en=1 with upd_way=hit_way for that cycle only.
REQ-023 SHALL hold mem_req=1 and mem_we=0 throughout MEM_RD, and mem_req=1 and mem_we=1 throughout MEM_WR; mem_req=0 in all other states.
REQ-024 SHALL leave MEM_RD to FILL, and MEM_WR to DONE, on the cycle mem_ack=1 is sampled; mem_ack SHALL be ignored in all other states.
REQ-025 SHALL keep an 8-entry x 1-bit FIFO victim pointer, one entry per index; fill_way SHALL equal ptr[line_index] combinationally.
REQ-026 SHALL assert fill_en=1 for exactly the one FILL cycle, toggle ptr[line_index] at the end of that cycle, then go to DONE.
REQ-027 SHALL leave ptr unchanged on read hits, write hits and write misses; fills to one index SHALL alternate ways 0,1,0,1 independently of other indices.
REQ-028 SHALL assert cpu_ready=1 only in DONE (one cycle), then return to IDLE.
REQ-029 SHALL hold line_index stable from LOOKUP through DONE.
REQ-030 SHALL give latency, in cycles from accept edge to cpu_ready: read hit 2; read miss 3 + memory wait; write 2 + memory wait.

Reset
REQ-031 SHALL, while reset=0 and independent of clk, force state=IDLE; all ptr entries=0; mem_req, mem_we, fill_en, upd_en, cpu_ready=0; line_index=0; latched cpu_we=0.
REQ-032 SHALL abort any in-flight transaction when reset is asserted mid-operation, dropping mem_req at once; a mem_ack arriving after release SHALL be ignored.
REQ-033 SHALL resume normal operation on the first posedge clk after reset returns to 1.

Verification
REQ-034 Read hit: reset, then cpu_req=1, we=0, idx=3, hit=1 -> LOOKUP then DONE; cpu_ready pulses 2 cycles after accept; mem_req stays 0.
REQ-035 Read miss x3 on idx=5, mem_ack 4 cycles after each request -> fill_en with fill_way 0, 1, 0; ptr for idx 2 stays 0.
REQ-036 Write hit: idx=1, hit=1, hit_way=1 -> upd_en=1 and upd_way=1 in LOOKUP; mem_req=1 and mem_we=1 until ack; ptr unchanged; no fill_en.
REQ-037 Write miss: idx=7, hit=0 -> MEM_WR, no upd_en, no fill_en; cpu_ready after mem_ack.
REQ-038 Reset mid-MEM_RD: reset=0 asynchronously -> mem_req=0 and state=IDLE immediately; a stray mem_ack after release -> no fill_en and no cpu_ready.
REQ-039 cpu_req held high through a miss -> exactly one transaction completes; the next is accepted only in IDLE after DONE.

Source files
------------

// File: rtl/cache_ctrl_fifo2w.sv
// Two-way cache controller: write-through, no write-allocate, read-miss refill.
// Victim selection is a per-index 1-bit FIFO pointer that alternates ways on each fill.
module cache_ctrl_fifo2w (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [2:0] cpu_index,
  input  logic       hit,
  input  logic       hit_way,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       fill_en,
  output logic       fill_way,
  output logic       upd_en,
  output logic       upd_way,
  output logic [2:0] line_index,
  output logic       cpu_ready,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MEM_RD = 3'd2,
    S_FILL   = 3'd3,
    S_MEM_WR = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_we;
  logic [2:0] r_index;
  logic [7:0] r_ptr;
  logic       w_latch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_index <= 3'd0;
      r_ptr   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_we    <= cpu_we;
        r_index <= cpu_index;
      end
      // The victim pointer only advances once the refilled line has been written.
      if (r_state == S_FILL) begin
        r_ptr[r_index] <= ~r_ptr[r_index];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    fill_en      = 1'b0;
    upd_en       = 1'b0;
    upd_way      = 1'b0;
    cpu_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          w_latch      = 1'b1;
          w_state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (r_we) begin
          // Write-through: a hit also updates the cached copy, a miss does not allocate.
          upd_en       = hit;
          upd_way      = hit ? hit_way : 1'b0;
          w_state_next = S_MEM_WR;
        end else begin
          w_state_next = hit ? S_DONE : S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_state_next = S_FILL;
        end
      end
      S_FILL: begin
        fill_en      = 1'b1;
        w_state_next = S_DONE;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        cpu_ready    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign fill_way   = r_ptr[r_index];
  assign line_index = r_index;
  assign state      = r_state;

endmodule

// File: tb/tb_cache_ctrl_fifo2w.sv
// Scoreboard bench for cache_ctrl_fifo2w: stimulus pushes expected upd/fill/ready
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_cache_ctrl_fifo2w;

  logic       clk;
  logic       reset;
  logic       cpu_req;
  logic       cpu_we;
  logic [2:0] cpu_index;
  logic       hit;
  logic       hit_way;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       fill_en;
  logic       fill_way;
  logic       upd_en;
  logic       upd_way;
  logic [2:0] line_index;
  logic       cpu_ready;
  logic [2:0] state;

  cache_ctrl_fifo2w dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_index  (cpu_index),
    .hit        (hit),
    .hit_way    (hit_way),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .fill_en    (fill_en),
    .fill_way   (fill_way),
    .upd_en     (upd_en),
    .upd_way    (upd_way),
    .line_index (line_index),
    .cpu_ready  (cpu_ready),
    .state      (state)
  );

  localparam int K_UPD  = 0;
  localparam int K_FILL = 1;
  localparam int K_RDY  = 2;

  typedef struct {
    int         kind;
    logic       way;
    logic [2:0] idx;
    int         lat;
  } ev_t;

  ev_t  sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic mptr [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input int k, input logic w);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d idx=%0d expected none", k, line_index);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || (k != K_RDY && e.way != w) || e.idx != line_index ||
          (cyc - accept_cyc) != e.lat) begin
        bad++;
        $display("FAIL event: got kind=%0d way=%0d idx=%0d lat=%0d expected kind=%0d way=%0d idx=%0d lat=%0d",
                 k, w, line_index, cyc - accept_cyc, e.kind, e.way, e.idx, e.lat);
      end else if (k == K_RDY) begin
        $display("txn done: idx=%0d latency=%0d", line_index, cyc - accept_cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (upd_en)    check_ev(K_UPD, upd_way);
      if (fill_en)   check_ev(K_FILL, fill_way);
      if (cpu_ready) check_ev(K_RDY, 1'b0);
    end
  end

  task automatic push(input int k, input logic w, input logic [2:0] i, input int l);
    ev_t e;
    e.kind = k;
    e.way  = w;
    e.idx  = i;
    e.lat  = l;
    sb.push_back(e);
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 once it is IDLE again.
  task automatic do_txn(input logic we, input logic [2:0] idx, input logic h, input logic hw,
                        input int wt, input logic hold);
    bit done;
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_index  = idx;
    hit        = h;
    hit_way    = hw;
    accept_cyc = cyc;
    if (we && h) push(K_UPD, hw, idx, 1);
    if (!we && !h) begin
      push(K_FILL, mptr[idx], idx, 2 + wt);
      mptr[idx] = ~mptr[idx];
    end
    push(K_RDY, 1'b0, idx, (!we && h) ? 2 : (!we ? 3 + wt : 2 + wt));
    @(posedge clk); #1;
    if (!hold) cpu_req = 1'b0;
    cpu_index = ~idx;
    cpu_we    = ~we;
    chk("lookup_state", state, 1);
    chk("lookup_mem_req", mem_req, 0);
    if (we || !h) begin
      for (int i = 1; i <= wt; i++) begin
        @(posedge clk); #1;
        chk("mem_req_level", mem_req, 1);
        chk("mem_we_level", mem_we, we);
        if (i == wt) mem_ack = 1'b1;
      end
    end
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (state == 3'd0) done = 1;
      else chk("mem_req_idle", mem_req, 0);
    end
    if (!done) chk("txn_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mptr[i] = 1'b0;
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_index = 3'd0;
    hit = 1'b0; hit_way = 1'b0; mem_ack = 1'b0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_line_index", line_index, 0);
    chk("rst_fill_way", fill_way, 0);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b0, 3'd3, 1'b1, 1'b0, 0, 1'b0);   // read hit
    do_txn(1'b0, 3'd5, 1'b0, 1'b0, 4, 1'b0);   // read misses, ways 0,1,0
    do_txn(1'b0, 3'd5, 1'b0, 1'b0, 4, 1'b0);
    do_txn(1'b0, 3'd5, 1'b0, 1'b0, 4, 1'b0);
    do_txn(1'b0, 3'd2, 1'b0, 1'b0, 2, 1'b0);   // untouched index still way 0
    do_txn(1'b1, 3'd1, 1'b1, 1'b1, 3, 1'b0);   // write hit
    do_txn(1'b0, 3'd1, 1'b0, 1'b0, 1, 1'b0);   // ptr unchanged by write hit
    do_txn(1'b1, 3'd7, 1'b0, 1'b0, 2, 1'b0);   // write miss
    do_txn(1'b0, 3'd7, 1'b0, 1'b0, 1, 1'b0);   // ptr unchanged by write miss

    // Abort a read miss while in MEM_RD.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_index = 3'd4; hit = 1'b0;
    @(posedge clk); #1 cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_mem_rd", state, 2);
    chk("abort_mem_req_before", mem_req, 1);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("abort_mem_req_async", mem_req, 0);
    chk("abort_state_async", state, 0);
    for (int i = 0; i < 8; i++) mptr[i] = 1'b0;
    @(posedge clk); @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_ack_state", state, 0);

    do_txn(1'b0, 3'd5, 1'b0, 1'b0, 1, 1'b0);   // ptr cleared by reset
    do_txn(1'b0, 3'd6, 1'b0, 1'b0, 2, 1'b1);   // cpu_req held through a miss
    chk("held_req_idle", state, 0);
    do_txn(1'b0, 3'd0, 1'b1, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
